// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared constants for the adder arbiter and its adder core.
//   OP_* : 2-bit operation code, [1] = signed, [0] = subtract.
//   ID_* : requester identifiers carried back on the response channel.
//   rsp_state_e : occupancy of the single response register.
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [1:0] OP_ADDU = 2'b00;
    localparam logic [1:0] OP_SUBU = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    localparam logic ID_EX = 1'b0;
    localparam logic ID_BR = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/adder_core.sv
// ----------------------------------------------------------------------------
// adder_core
//   Pure combinational WIDTH-bit add/subtract with status flags.
//   Ports:
//     op_i    [1:0]      [1] = signed, [0] = subtract
//     a_i     [WIDTH-1:0] operand a
//     b_i     [WIDTH-1:0] operand b
//     sum_o   [WIDTH-1:0] a+b or a-b, modulo 2^WIDTH
//     carry_o            unsigned only: add carry-out / sub borrow (a < b)
//     neg_o              signed only: sum_o[WIDTH-1]
//     ovf_o              signed only: two's-complement overflow
// ----------------------------------------------------------------------------
module adder_core #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             neg_o,
    output logic             ovf_o
);

    logic [WIDTH:0] ext;
    logic           is_signed;
    logic           is_sub;
    logic           sovf;

    always_comb begin
        is_signed = op_i[1];
        is_sub    = op_i[0];
        // Zero-extended by one bit: for add the top bit is the carry-out,
        // for subtract it goes high exactly when a < b (borrow).
        if (is_sub) begin
            ext = {1'b0, a_i} - {1'b0, b_i};
        end else begin
            ext = {1'b0, a_i} + {1'b0, b_i};
        end
        sum_o = ext[WIDTH-1:0];

        if (is_sub) begin
            sovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) & (sum_o[WIDTH-1] != a_i[WIDTH-1]);
        end else begin
            sovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) & (sum_o[WIDTH-1] != a_i[WIDTH-1]);
        end

        carry_o = ~is_signed & ext[WIDTH];
        neg_o   =  is_signed & sum_o[WIDTH-1];
        ovf_o   =  is_signed & sovf;
    end

endmodule

// File: rtl/adder_arbiter.sv
// ----------------------------------------------------------------------------
// adder_arbiter
//   Shares one combinational adder between two requesters (req0 = EX ALU,
//   req1 = branch/address unit). The granted operands are added in the
//   accept cycle and captured in a single response register.
//   Ports:
//     iClk, iRst                       clock, synchronous active-high reset
//     iReqN_valid / oReqN_ready        operand handshake, N = 0,1
//     iReqN_op [1:0], iReqN_a, iReqN_b operation and operands
//     oRsp_valid / iRsp_ready          response handshake
//     oRsp_id                          owner of the response (0 = req0)
//     oRsp_data                        result, modulo 2^WIDTH
//     oRsp_carry / oRsp_neg / oRsp_ovf status flags
//   RR_EN = 1 selects round-robin on ties, 0 gives req0 fixed priority.
// ----------------------------------------------------------------------------
module adder_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter bit RR_EN = 1'b1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iReq0_valid,
    output logic             oReq0_ready,
    input  logic [1:0]       iReq0_op,
    input  logic [WIDTH-1:0] iReq0_a,
    input  logic [WIDTH-1:0] iReq0_b,
    input  logic             iReq1_valid,
    output logic             oReq1_ready,
    input  logic [1:0]       iReq1_op,
    input  logic [WIDTH-1:0] iReq1_a,
    input  logic [WIDTH-1:0] iReq1_b,
    output logic             oRsp_valid,
    input  logic             iRsp_ready,
    output logic             oRsp_id,
    output logic [WIDTH-1:0] oRsp_data,
    output logic             oRsp_carry,
    output logic             oRsp_neg,
    output logic             oRsp_ovf
);

    rsp_state_e       state_q, state_d;
    logic             rr_last_q, rr_last_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             carry_q, carry_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;

    logic             free;
    logic             grant0;
    logic             grant1;
    logic             xfer;
    logic [1:0]       mux_op;
    logic [WIDTH-1:0] mux_a;
    logic [WIDTH-1:0] mux_b;
    logic [WIDTH-1:0] core_sum;
    logic             core_carry;
    logic             core_neg;
    logic             core_ovf;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (xfer) state_d = ST_FULL;
            ST_FULL:  if (iRsp_ready && !xfer) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // ---------------- FSM: outputs and grant ----------------
    always_comb begin
        oRsp_valid = (state_q == ST_FULL);
        // Slot is free when empty or being drained this cycle.
        free = !oRsp_valid || iRsp_ready;
        // On a tie, round-robin hands the grant to whoever did not win last.
        if (RR_EN) begin
            grant0 = iReq0_valid && (!iReq1_valid || rr_last_q);
        end else begin
            grant0 = iReq0_valid;
        end
        grant1 = iReq1_valid && !grant0;
        // Nothing is accepted while reset is asserted.
        oReq0_ready = free && grant0 && !iRst;
        oReq1_ready = free && grant1 && !iRst;
        xfer        = (iReq0_valid && oReq0_ready) || (iReq1_valid && oReq1_ready);
    end

    // Operand mux feeding the shared adder
    always_comb begin
        mux_op = grant1 ? iReq1_op : iReq0_op;
        mux_a  = grant1 ? iReq1_a  : iReq0_a;
        mux_b  = grant1 ? iReq1_b  : iReq0_b;
    end

    adder_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_i    (mux_op),
        .a_i     (mux_a),
        .b_i     (mux_b),
        .sum_o   (core_sum),
        .carry_o (core_carry),
        .neg_o   (core_neg),
        .ovf_o   (core_ovf)
    );

    // Response contents and rr_last change only on an accepted transfer.
    always_comb begin
        data_d    = data_q;
        carry_d   = carry_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        id_d      = id_q;
        rr_last_d = rr_last_q;
        if (xfer) begin
            data_d    = core_sum;
            carry_d   = core_carry;
            neg_d     = core_neg;
            ovf_d     = core_ovf;
            id_d      = grant1 ? ID_BR : ID_EX;
            rr_last_d = grant1 ? ID_BR : ID_EX;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            data_q    <= '0;
            carry_q   <= 1'b0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            id_q      <= ID_EX;
            rr_last_q <= 1'b1;
        end else begin
            data_q    <= data_d;
            carry_q   <= carry_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            id_q      <= id_d;
            rr_last_q <= rr_last_d;
        end
    end

    assign oRsp_id    = id_q;
    assign oRsp_data  = data_q;
    assign oRsp_carry = carry_q;
    assign oRsp_neg   = neg_q;
    assign oRsp_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: a round-robin and a fixed-priority
// instance share the same stimulus.
module tb_adder_arbiter;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         v0, v1, rsp_ready;
    logic [1:0]   op0, op1;
    logic [W-1:0] a0, b0, a1, b1;

    logic         r_rdy0, r_rdy1, r_vld, r_id, r_c, r_n, r_o;
    logic [W-1:0] r_data;
    logic         f_rdy0, f_rdy1, f_vld, f_id, f_c, f_n, f_o;
    logic [W-1:0] f_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.WIDTH(W), .RR_EN(1'b1)) u_rr (
        .iClk(clk), .iRst(rst),
        .iReq0_valid(v0), .oReq0_ready(r_rdy0), .iReq0_op(op0), .iReq0_a(a0), .iReq0_b(b0),
        .iReq1_valid(v1), .oReq1_ready(r_rdy1), .iReq1_op(op1), .iReq1_a(a1), .iReq1_b(b1),
        .oRsp_valid(r_vld), .iRsp_ready(rsp_ready), .oRsp_id(r_id), .oRsp_data(r_data),
        .oRsp_carry(r_c), .oRsp_neg(r_n), .oRsp_ovf(r_o)
    );

    adder_arbiter #(.WIDTH(W), .RR_EN(1'b0)) u_fp (
        .iClk(clk), .iRst(rst),
        .iReq0_valid(v0), .oReq0_ready(f_rdy0), .iReq0_op(op0), .iReq0_a(a0), .iReq0_b(b0),
        .iReq1_valid(v1), .oReq1_ready(f_rdy1), .iReq1_op(op1), .iReq1_a(a1), .iReq1_b(b1),
        .oRsp_valid(f_vld), .iRsp_ready(rsp_ready), .oRsp_id(f_id), .oRsp_data(f_data),
        .oRsp_carry(f_c), .oRsp_neg(f_n), .oRsp_ovf(f_o)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
        op0 = OP_ADDU; op1 = OP_ADDU; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        step(); step();
        rst = 1'b0;
        step();
        checks++; if (r_vld !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", r_vld); end
        checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", r_data); end
        checks++; if ({r_c, r_n, r_o, r_id} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {r_c, r_n, r_o, r_id}); end
        checks++; if ({r_rdy0, r_rdy1, f_rdy0, f_rdy1} !== 4'b0) begin errors++; $display("FAIL idle_ready got=%b exp=0000", {r_rdy0, r_rdy1, f_rdy0, f_rdy1}); end
    endtask

    task automatic test_unsigned();
        v0 = 1'b1; op0 = OP_ADDU; a0 = 32'hFFFF_FFFF; b0 = 32'h1;
        #1;
        checks++; if ({r_rdy0, r_rdy1} !== 2'b10) begin errors++; $display("FAIL addu_ready got=%b exp=10", {r_rdy0, r_rdy1}); end
        step();
        v0 = 1'b0;
        checks++; if (r_vld !== 1'b1) begin errors++; $display("FAIL addu_valid got=%b exp=1", r_vld); end
        checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL addu_data got=%h exp=00000000", r_data); end
        checks++; if ({r_id, r_c, r_n, r_o} !== 4'b0100) begin errors++; $display("FAIL addu_flags got=%b exp=0100", {r_id, r_c, r_n, r_o}); end
        v1 = 1'b1; op1 = OP_SUBU; a1 = 32'd3; b1 = 32'd5;
        step();
        v1 = 1'b0;
        checks++; if (r_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL subu_data got=%h exp=FFFFFFFE", r_data); end
        checks++; if ({r_id, r_c, r_n, r_o} !== 4'b1100) begin errors++; $display("FAIL subu_flags got=%b exp=1100", {r_id, r_c, r_n, r_o}); end
    endtask

    task automatic test_signed();
        v0 = 1'b1; op0 = OP_ADD; a0 = 32'h7FFF_FFFF; b0 = 32'h1;
        step();
        v0 = 1'b0;
        checks++; if (r_data !== 32'h8000_0000) begin errors++; $display("FAIL add_data got=%h exp=80000000", r_data); end
        checks++; if ({r_c, r_n, r_o} !== 3'b011) begin errors++; $display("FAIL add_flags got=%b exp=011", {r_c, r_n, r_o}); end
        v0 = 1'b1; op0 = OP_SUB; a0 = 32'h8000_0000; b0 = 32'h1;
        step();
        v0 = 1'b0;
        checks++; if (r_data !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub_data got=%h exp=7FFFFFFF", r_data); end
        checks++; if ({r_c, r_n, r_o} !== 3'b001) begin errors++; $display("FAIL sub_flags got=%b exp=001", {r_c, r_n, r_o}); end
    endtask

    task automatic test_back_to_back();
        logic exp_id;
        // Fresh reset so rr_last starts at 1 and req0 wins the first tie.
        rst = 1'b1; step(); rst = 1'b0;
        rsp_ready = 1'b1;
        op0 = OP_ADDU; op1 = OP_ADDU; b0 = 32'd10; b1 = 32'd10;
        for (int i = 0; i < 4; i++) begin
            v0 = 1'b1; v1 = 1'b1; a0 = i; a1 = i;
            exp_id = i[0];
            #1;
            checks++; if ({r_rdy0, r_rdy1} !== {~exp_id, exp_id}) begin errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, {r_rdy0, r_rdy1}, {~exp_id, exp_id}); end
            checks++; if ({f_rdy0, f_rdy1} !== 2'b10) begin errors++; $display("FAIL fp_ready[%0d] got=%b exp=10", i, {f_rdy0, f_rdy1}); end
            step();
            checks++; if ({r_vld, r_id} !== {1'b1, exp_id}) begin errors++; $display("FAIL rr_id[%0d] got=%b exp=%b", i, {r_vld, r_id}, {1'b1, exp_id}); end
            checks++; if ({f_vld, f_id} !== 2'b10) begin errors++; $display("FAIL fp_id[%0d] got=%b exp=10", i, {f_vld, f_id}); end
            checks++; if (r_data !== 32'(i + 10)) begin errors++; $display("FAIL rr_data[%0d] got=%0d exp=%0d", i, r_data, i + 10); end
        end
        v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic test_stall();
        // Holding the last back-to-back result: 3+10 from req1.
        rsp_ready = 1'b0;
        v0 = 1'b1; v1 = 1'b1; op0 = OP_ADDU; op1 = OP_ADDU;
        a0 = 32'd100; b0 = 32'd1; a1 = 32'd100; b1 = 32'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({r_rdy0, r_rdy1} !== 2'b00) begin errors++; $display("FAIL stall_ready[%0d] got=%b exp=00", i, {r_rdy0, r_rdy1}); end
            checks++; if ({r_vld, r_id, r_data} !== {1'b1, 1'b1, 32'd13}) begin errors++; $display("FAIL stall_hold[%0d] got=%b/%b/%0d exp=1/1/13", i, r_vld, r_id, r_data); end
            step();
        end
        rsp_ready = 1'b1; v0 = 1'b0;
        #1;
        checks++; if ({r_rdy0, r_rdy1} !== 2'b01) begin errors++; $display("FAIL drain_ready got=%b exp=01", {r_rdy0, r_rdy1}); end
        step();
        v1 = 1'b0;
        checks++; if ({r_vld, r_id, r_data} !== {1'b1, 1'b1, 32'd101}) begin errors++; $display("FAIL drain_accept got=%b/%b/%0d exp=1/1/101", r_vld, r_id, r_data); end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        rst = 1'b1;
        v0 = 1'b1; op0 = OP_ADDU; a0 = 32'd5; b0 = 32'd5;
        #1;
        checks++; if ({r_rdy0, r_rdy1} !== 2'b00) begin errors++; $display("FAIL rst_ready got=%b exp=00", {r_rdy0, r_rdy1}); end
        rsp_ready = 1'b1;
        #1;
        checks++; if ({r_rdy0, f_rdy0} !== 2'b00) begin errors++; $display("FAIL rst_ready_free got=%b exp=00", {r_rdy0, f_rdy0}); end
        step();
        rst = 1'b0;
        checks++; if (r_vld !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", r_vld); end
        checks++; if (r_data !== 32'h0) begin errors++; $display("FAIL rst_mid_data got=%h exp=0", r_data); end
        step();
        v0 = 1'b0;
        checks++; if ({r_vld, r_id, r_data} !== {1'b1, 1'b0, 32'd10}) begin errors++; $display("FAIL post_rst_accept got=%b/%b/%0d exp=1/0/10", r_vld, r_id, r_data); end
        step();
        checks++; if (r_vld !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", r_vld); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
